// File: rtl/ibex_multdiv_iter_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package ibex_multdiv_iter_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [2:0] {
    IDLE,
    ABS_A,
    ABS_B,
    COMP,
    LAST,
    CHSIGN,
    FINISH
  } md_fsm_e;

endpackage

// File: rtl/ibex_multdiv_iter_if.sv
// Controller-side request/response bundle of the multiply/divide unit.
interface ibex_multdiv_iter_if;
  import ibex_multdiv_iter_pkg::*;

  logic            mult_en_i;
  logic            div_en_i;
  md_op_e          operator_i;
  logic [1:0]      signed_mode_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic [XLEN-1:0] result_o;
  logic            valid_o;

  modport master (
    output mult_en_i, div_en_i, operator_i, signed_mode_i, op_a_i, op_b_i,
    input  result_o, valid_o
  );

  modport slave (
    input  mult_en_i, div_en_i, operator_i, signed_mode_i, op_a_i, op_b_i,
    output result_o, valid_o
  );
endinterface

// File: rtl/ibex_multdiv_iter_opmux.sv
// Selects the shared ALU adder operands for each multdiv state.
// Bit 0 of each operand is the carry-in trick: a[0]=1, b[0]=1 adds one more.
module ibex_multdiv_iter_opmux
  import ibex_multdiv_iter_pkg::*;
(
  input  md_fsm_e         state,
  input  logic            is_div,
  input  logic            booth_sub,
  input  logic [XLEN-1:0] mul_addend,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] divisor,
  input  logic [XLEN-1:0] mreg,
  output logic [XLEN:0]   operand_a,
  output logic [XLEN:0]   operand_b
);

  // Negations compute 0 + ~x + 1; compare/subtract computes r + ~d + 1
  always_comb begin
    operand_a = '0;
    operand_b = '0;
    case (state)
      ABS_A: begin
        operand_a = {{XLEN{1'b0}}, 1'b1};
        operand_b = {~mreg, 1'b1};
      end
      ABS_B: begin
        operand_a = {{XLEN{1'b0}}, 1'b1};
        operand_b = {~divisor, 1'b1};
      end
      CHSIGN: begin
        operand_a = {{XLEN{1'b0}}, 1'b1};
        operand_b = {~acc, 1'b1};
      end
      COMP: begin
        if (is_div) begin
          operand_a = {acc[XLEN-2:0], mreg[XLEN-1], 1'b1};
          operand_b = {~divisor, 1'b1};
        end else begin
          operand_a = {acc, 1'b1};
          operand_b = {mul_addend, booth_sub};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ibex_multdiv_iter.sv
// Iterative RV32M multiply/divide unit sharing the ALU adder, one bit per cycle.
// Optional: define IBEX_MULTDIV_DIV0_SHORTCUT_EN to finish divide-by-zero
// straight from ABS_A.
module ibex_multdiv_iter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ibex_multdiv_iter_if.slave  md,
  input  logic [XLEN+1:0]     alu_adder_ext_i,
  output logic [XLEN:0]       alu_operand_a_o,
  output logic [XLEN:0]       alu_operand_b_o,
  output logic                multdiv_sel_o
);
  import ibex_multdiv_iter_pkg::*;

  md_fsm_e         state_q, state_d;
  md_op_e          operator_q;
  logic            is_div_q, signed_b_q, a_neg_q, b_neg_q, div0_q;
  logic [XLEN:0]   acc_q, op_q;
  logic [XLEN-1:0] mreg_q, result_q;
  logic [CNT_W-1:0] cnt_q;

  logic            active_en, accept, abort, last_iter, valid;
  logic [XLEN-1:0] adder_sum;
  logic            adder_carry, unused_adder_lsb;
  logic            booth_sub, ext_c33, div_take, chsign_neg;
  logic [XLEN:0]   mul_addend, mul_acc_nxt, div_acc_nxt;
  logic [XLEN-1:0] mul_mreg_nxt, div_mreg_nxt;

  assign adder_sum        = alu_adder_ext_i[XLEN:1];
  assign adder_carry      = alu_adder_ext_i[XLEN+1];
  assign unused_adder_lsb = alu_adder_ext_i[0];

  assign active_en  = is_div_q ? md.div_en_i : md.mult_en_i;
  assign accept     = (state_q == IDLE) && (md.mult_en_i || md.div_en_i);
  assign abort      = (state_q != IDLE) && (state_q != FINISH) && !active_en;
  assign last_iter  = (cnt_q == '0);
  assign chsign_neg = (operator_q == MD_OP_REM) ? a_neg_q
                                                : ((a_neg_q ^ b_neg_q) & ~div0_q);

  // Per-iteration datapath values.
  // The adder is only 32 bits wide; bits 32/33 of the 34-bit sign-extended
  // multiply sum are rebuilt from the operand top bits and the adder carry.
  always_comb begin
    booth_sub    = mreg_q[0] & last_iter & signed_b_q;
    mul_addend   = mreg_q[0] ? (booth_sub ? ~op_q : op_q) : '0;
    ext_c33      = (acc_q[XLEN] & mul_addend[XLEN]) |
                   ((acc_q[XLEN] ^ mul_addend[XLEN]) & adder_carry);
    mul_acc_nxt  = {acc_q[XLEN] ^ mul_addend[XLEN] ^ ext_c33,
                    acc_q[XLEN] ^ mul_addend[XLEN] ^ adder_carry,
                    adder_sum[XLEN-1:1]};
    mul_mreg_nxt = {adder_sum[0], mreg_q[XLEN-1:1]};
    // A set top bit in the shifted remainder always exceeds the divisor
    div_take     = acc_q[XLEN-1] | adder_carry;
    div_acc_nxt  = div_take ? {1'b0, adder_sum}
                            : {1'b0, acc_q[XLEN-2:0], mreg_q[XLEN-1]};
    div_mreg_nxt = {mreg_q[XLEN-2:0], div_take};
  end

  ibex_multdiv_iter_opmux u_opmux (
    .state      (state_q),
    .is_div     (is_div_q),
    .booth_sub  (booth_sub),
    .mul_addend (mul_addend[XLEN-1:0]),
    .acc        (acc_q[XLEN-1:0]),
    .divisor    (op_q[XLEN-1:0]),
    .mreg       (mreg_q),
    .operand_a  (alu_operand_a_o),
    .operand_b  (alu_operand_b_o)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state sequencing; a dropped enable aborts to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (md.div_en_i)       state_d = ABS_A;
        else if (md.mult_en_i) state_d = COMP;
      end
`ifdef IBEX_MULTDIV_DIV0_SHORTCUT_EN
      ABS_A:  state_d = div0_q ? FINISH : ABS_B;
`else
      ABS_A:  state_d = ABS_B;
`endif
      ABS_B:  state_d = COMP;
      COMP:   if (last_iter) state_d = is_div_q ? LAST : FINISH;
      LAST:   state_d = CHSIGN;
      CHSIGN: state_d = FINISH;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Output decode: adder ownership and completion pulse
  always_comb begin
    multdiv_sel_o = 1'b0;
    valid         = 1'b0;
    case (state_q)
      IDLE:    ;
      FINISH:  valid = 1'b1;
      default: multdiv_sel_o = 1'b1;
    endcase
  end

  assign md.valid_o  = valid;
  assign md.result_o = result_q;

  // Operand latch, iteration updates and result capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      operator_q <= MD_OP_MULL;
      is_div_q <= 1'b0; signed_b_q <= 1'b0; a_neg_q <= 1'b0; b_neg_q <= 1'b0; div0_q <= 1'b0;
      acc_q <= '0; op_q <= '0; mreg_q <= '0; result_q <= '0; cnt_q <= '0;
    end else if (abort) begin
      operator_q <= MD_OP_MULL;
      is_div_q <= 1'b0; signed_b_q <= 1'b0; a_neg_q <= 1'b0; b_neg_q <= 1'b0; div0_q <= 1'b0;
      acc_q <= '0; op_q <= '0; mreg_q <= '0; result_q <= '0; cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            is_div_q   <= md.div_en_i;
            operator_q <= md.operator_i;
            signed_b_q <= md.signed_mode_i[1];
            a_neg_q    <= md.signed_mode_i[0] & md.op_a_i[XLEN-1];
            b_neg_q    <= md.signed_mode_i[1] & md.op_b_i[XLEN-1];
            div0_q     <= (md.op_b_i == '0);
            acc_q      <= '0;
            cnt_q      <= '1;
            result_q   <= '0;
            mreg_q     <= md.div_en_i ? md.op_a_i : md.op_b_i;
            op_q       <= md.div_en_i ? {1'b0, md.op_b_i}
                                      : {md.signed_mode_i[0] & md.op_a_i[XLEN-1], md.op_a_i};
          end
        end
        ABS_A: begin
          if (a_neg_q) mreg_q <= adder_sum;
`ifdef IBEX_MULTDIV_DIV0_SHORTCUT_EN
          if (div0_q) result_q <= (operator_q == MD_OP_REM) ? mreg_q : '1;
`endif
        end
        ABS_B: begin
          if (b_neg_q) op_q <= {1'b0, adder_sum};
        end
        COMP: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (is_div_q) begin
            acc_q  <= div_acc_nxt;
            mreg_q <= div_mreg_nxt;
          end else begin
            acc_q  <= mul_acc_nxt;
            mreg_q <= mul_mreg_nxt;
            if (last_iter)
              result_q <= (operator_q == MD_OP_MULL) ? mul_mreg_nxt : mul_acc_nxt[XLEN-1:0];
          end
        end
        LAST: begin
          acc_q <= {1'b0, (operator_q == MD_OP_REM) ? acc_q[XLEN-1:0] : mreg_q};
        end
        CHSIGN: begin
          result_q <= chsign_neg ? adder_sum : acc_q[XLEN-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Scoreboard bench for ibex_multdiv_iter with a behavioural ALU adder model.
module tb_ibex_multdiv_iter;
  import ibex_multdiv_iter_pkg::*;

`ifdef IBEX_MULTDIV_DIV0_SHORTCUT_EN
  localparam bit SHORTCUT = 1'b1;
`else
  localparam bit SHORTCUT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [33:0] alu_adder_ext;
  logic [32:0] alu_operand_a, alu_operand_b;
  logic        multdiv_sel;

  ibex_multdiv_iter_if md();

  ibex_multdiv_iter #(.XLEN(32), .CNT_W(5)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .md              (md),
    .alu_adder_ext_i (alu_adder_ext),
    .alu_operand_a_o (alu_operand_a),
    .alu_operand_b_o (alu_operand_b),
    .multdiv_sel_o   (multdiv_sel)
  );

  always #5 clk = ~clk;

  // ALU extended adder: plain 34-bit sum of the two 33-bit operands
  assign alu_adder_ext = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};

  typedef struct {
    logic [31:0] res;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input md_op_e op, input logic [1:0] sm,
                                             input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] ea, eb;
    logic        [65:0] p;
    logic signed [31:0] sa, sbv;
    if (op == MD_OP_MULL || op == MD_OP_MULH) begin
      ea = sm[0] ? {{34{a[31]}}, a} : {34'b0, a};
      eb = sm[1] ? {{34{b[31]}}, b} : {34'b0, b};
      p  = ea * eb;
      return (op == MD_OP_MULL) ? p[31:0] : p[63:32];
    end
    if (b == '0) return (op == MD_OP_DIV) ? 32'hFFFF_FFFF : a;
    if (sm == 2'b11) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return (op == MD_OP_DIV) ? 32'h8000_0000 : 32'h0;
      sa  = a;
      sbv = b;
      return (op == MD_OP_DIV) ? sa / sbv : sa % sbv;
    end
    return (op == MD_OP_DIV) ? a / b : a % b;
  endfunction

  function automatic int unsigned ref_lat(input md_op_e op, input logic [31:0] b);
    if (op == MD_OP_MULL || op == MD_OP_MULH) return 33;
    if (SHORTCUT && b == '0) return 2;
    return 37;
  endfunction

  task automatic do_op(input string tag, input md_op_e op, input logic [1:0] sm,
                       input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    int unsigned cyc   = 0;
    int unsigned sel_n = 0;
    bit          got   = 1'b0;
    bit          is_div = (op == MD_OP_DIV) || (op == MD_OP_REM);
    e.res = ref_result(op, sm, a, b);
    e.lat = ref_lat(op, b);
    sb.push_back(e);
    md.operator_i    = op;
    md.signed_mode_i = sm;
    md.op_a_i        = a;
    md.op_b_i        = b;
    md.div_en_i      = is_div;
    md.mult_en_i     = !is_div;
    while (!got && cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (multdiv_sel) sel_n++;
      if (md.valid_o) begin
        got = 1'b1;
        e = sb.pop_front();
        check_eq({tag, " result"}, md.result_o, e.res);
        check_eq({tag, " latency"}, cyc, e.lat);
        check_eq({tag, " sel cycles"}, sel_n, e.lat - 1);
      end
    end
    md.mult_en_i = 1'b0;
    md.div_en_i  = 1'b0;
    if (!got) begin
      e = sb.pop_front();
      check_eq({tag, " timeout"}, got, 1);
    end
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, " pulse"}, md.valid_o, 0);
    check_eq({tag, " hold"}, md.result_o, e.res);
  endtask

  initial begin
    int unsigned vcount;
    md_op_e      op;
    logic [1:0]  sm;

    rst              = 1'b1;
    md.mult_en_i     = 1'b0;
    md.div_en_i      = 1'b0;
    md.operator_i    = MD_OP_MULL;
    md.signed_mode_i = 2'b00;
    md.op_a_i        = '0;
    md.op_b_i        = '0;
    repeat (2) @(negedge clk);
    check_eq("rst valid", md.valid_o, 0);
    check_eq("rst result", md.result_o, 0);
    check_eq("rst sel", multdiv_sel, 0);
    check_eq("rst alu_a", alu_operand_a, 0);
    check_eq("rst alu_b", alu_operand_b, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op("mull 7x6",      MD_OP_MULL, 2'b00, 32'd7, 32'd6);
    do_op("mulh s -1x-1",  MD_OP_MULH, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mulhu -1x-1",   MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mulhsu -1x2",   MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'd2);
    do_op("mull s min",    MD_OP_MULL, 2'b11, 32'h8000_0000, 32'h8000_0000);
    do_op("mulh s min",    MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000);
    do_op("div s -7/2",    MD_OP_DIV,  2'b11, 32'hFFFF_FFF9, 32'd2);
    do_op("rem s -7/2",    MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'd2);
    do_op("divu 100/0",    MD_OP_DIV,  2'b00, 32'd100, 32'd0);
    do_op("remu 100/0",    MD_OP_REM,  2'b00, 32'd100, 32'd0);
    do_op("div s -5/0",    MD_OP_DIV,  2'b11, 32'hFFFF_FFFB, 32'd0);
    do_op("rem s -5/0",    MD_OP_REM,  2'b11, 32'hFFFF_FFFB, 32'd0);
    do_op("div s ovf",     MD_OP_DIV,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem s ovf",     MD_OP_REM,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("divu big",      MD_OP_DIV,  2'b00, 32'hFFFF_FFFF, 32'h8000_0001);
    do_op("remu big",      MD_OP_REM,  2'b00, 32'hFFFF_FFFF, 32'h8000_0001);

    for (int i = 0; i < 12; i++) begin
      op = md_op_e'($urandom_range(0, 3));
      if (op == MD_OP_DIV || op == MD_OP_REM) sm = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
      else                                    sm = 2'($urandom_range(0, 3));
      do_op("random", op, sm, $urandom, (i % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom);
    end

    // Abort: drop div_en_i at cycle 10
    md.operator_i    = MD_OP_DIV;
    md.signed_mode_i = 2'b11;
    md.op_a_i        = 32'd1000;
    md.op_b_i        = 32'd7;
    md.div_en_i      = 1'b1;
    vcount = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (md.valid_o) vcount++;
    end
    check_eq("abort busy sel", multdiv_sel, 1);
    md.div_en_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort idle sel", multdiv_sel, 0);
    check_eq("abort alu_a", alu_operand_a, 0);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (md.valid_o) vcount++;
    end
    check_eq("abort no valid", vcount, 0);

    // Reset in the middle of a multiply
    md.operator_i    = MD_OP_MULL;
    md.signed_mode_i = 2'b00;
    md.op_a_i        = 32'd1234;
    md.op_b_i        = 32'd5678;
    md.mult_en_i     = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("mid busy sel", multdiv_sel, 1);
    check_eq("mid busy alu_a", alu_operand_a[0], 1);
    rst = 1'b1;
    #1;
    check_eq("mid rst valid", md.valid_o, 0);
    check_eq("mid rst result", md.result_o, 0);
    check_eq("mid rst sel", multdiv_sel, 0);
    check_eq("mid rst alu_a", alu_operand_a, 0);
    check_eq("mid rst alu_b", alu_operand_b, 0);
    md.mult_en_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op("post-rst mull", MD_OP_MULL, 2'b00, 32'd123456, 32'd789);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
